// File: rtl/ibex_rf_of_pkg.sv
// ibex_rf_of_pkg
// Shared types and constants for the register-file operand-fetch block.
//   of_state_e : operand-fetch FSM state encoding
//   RegZero    : index of the hard-wired zero register x0
package ibex_rf_of_pkg;

  typedef enum logic [1:0] {
    OF_IDLE  = 2'd0,
    OF_ISSUE = 2'd1,
    OF_WAIT  = 2'd2,
    OF_OUT   = 2'd3
  } of_state_e;

  localparam logic [4:0] RegZero = 5'd0;

endpackage

// File: rtl/ibex_rf_of_bypass.sv
// ibex_rf_of_bypass
// Capture-select mux for one operand. Produces the value the operand
// register should load when the fetch FSM captures.
// Ports:
//   addr_i      in  5          read address of this operand
//   rdata_i     in  DataWidth  register-file read data
//   wb_we_i     in  1          writeback enable
//   wb_waddr_i  in  5          writeback address
//   wb_wdata_i  in  DataWidth  writeback data
//   operand_o   out DataWidth  selected operand value
module ibex_rf_of_bypass
  import ibex_rf_of_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [4:0]           addr_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic [DataWidth-1:0] operand_o
);

  // x0 always reads zero, even if a writeback targets it; otherwise a
  // same-cycle writeback to the address wins over the (stale) read data.
  always_comb begin
    operand_o = rdata_i;
    if (addr_i == RegZero) begin
      operand_o = '0;
    end else if (wb_we_i && (wb_waddr_i == addr_i)) begin
      operand_o = wb_wdata_i;
    end
  end

endmodule

// File: rtl/ibex_rf_operand_fetch.sv
// ibex_rf_operand_fetch
// Requester side of the cached register-file read interface, between
// decode and execute. Latches source indices, holds the read addresses
// while the register file stalls, captures both operands (with writeback
// bypass) and offers them downstream on a valid/ready handshake. Keeps
// saturating miss / stall-cycle statistics and a sticky timeout flag.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   instr_valid_i/ready_o     request handshake from decode
//   rs1_i, rs2_i              source register indices
//   uses_rs1_i, uses_rs2_i    operand-required qualifiers
//   raddr_a_o, raddr_b_o      register-file read addresses
//   rdata_a_i, rdata_b_i      register-file read data
//   rf_stall_i                register-file stall
//   wb_we_i/waddr_i/wdata_i   writeback port (for bypass)
//   op_valid_o/op_ready_i     operand handshake to execute
//   op_a_o, op_b_o            captured operands
//   stall_timeout_o           sticky: a stall hit MaxStallCycles
//   miss_count_o              requests that saw a stall
//   stall_cycles_o            total cycles spent waiting
//
// state    | meaning
// ---------+------------------------------------------------------------
// OF_IDLE  | no request held, ready to accept
// OF_ISSUE | addresses presented, first register-file response cycle
// OF_WAIT  | register file stalling, addresses held, counting stall
// OF_OUT   | operands captured and offered to execute
module ibex_rf_operand_fetch
  import ibex_rf_of_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxStallCycles = 8,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic                 uses_rs1_i,
  input  logic                 uses_rs2_i,
  output logic [4:0]           raddr_a_o,
  output logic [4:0]           raddr_b_o,
  input  logic [DataWidth-1:0] rdata_a_i,
  input  logic [DataWidth-1:0] rdata_b_i,
  input  logic                 rf_stall_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [DataWidth-1:0] op_a_o,
  output logic [DataWidth-1:0] op_b_o,
  output logic                 stall_timeout_o,
  output logic [CntWidth-1:0]  miss_count_o,
  output logic [CntWidth-1:0]  stall_cycles_o
);

  localparam logic [7:0] MaxStall = 8'(MaxStallCycles);

  of_state_e             state_q, state_d;
  logic [4:0]            ra_q, rb_q;
  logic [DataWidth-1:0]  op_a_q, op_b_q;
  logic [DataWidth-1:0]  cap_a, cap_b;
  logic [7:0]            stall_cnt_q;
  logic                  timeout_q;
  logic [CntWidth-1:0]   miss_q, stall_q;

  logic                  in_issue, in_wait, in_out;
  logic                  accept, handshake, force_cap, capture;

  assign in_issue = (state_q == OF_ISSUE);
  assign in_wait  = (state_q == OF_WAIT);
  assign in_out   = (state_q == OF_OUT);

  assign handshake     = in_out && op_ready_i;
  assign instr_ready_o = (state_q == OF_IDLE) || handshake;
  assign accept        = instr_valid_i && instr_ready_o;

  // stall_cnt_q holds the number of earlier WAIT cycles, so this WAIT
  // cycle is number stall_cnt_q+1; give up once that reaches the limit.
  assign force_cap = in_wait && rf_stall_i && ((stall_cnt_q + 8'd1) == MaxStall);
  assign capture   = (in_issue && !rf_stall_i) || (in_wait && (!rf_stall_i || force_cap));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OF_IDLE:  if (accept) state_d = OF_ISSUE;
      OF_ISSUE: state_d = rf_stall_i ? OF_WAIT : OF_OUT;
      OF_WAIT:  if (capture) state_d = OF_OUT;
      OF_OUT: begin
        if (handshake) state_d = accept ? OF_ISSUE : OF_IDLE;
      end
      default:  state_d = OF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unused operands read x0 so they can never provoke a cache miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ra_q <= RegZero;
      rb_q <= RegZero;
    end else if (accept) begin
      ra_q <= uses_rs1_i ? rs1_i : RegZero;
      rb_q <= uses_rs2_i ? rs2_i : RegZero;
    end
  end

  ibex_rf_of_bypass #(
    .DataWidth (DataWidth)
  ) u_bypass_a (
    .addr_i     (ra_q),
    .rdata_i    (rdata_a_i),
    .wb_we_i    (wb_we_i),
    .wb_waddr_i (wb_waddr_i),
    .wb_wdata_i (wb_wdata_i),
    .operand_o  (cap_a)
  );

  ibex_rf_of_bypass #(
    .DataWidth (DataWidth)
  ) u_bypass_b (
    .addr_i     (rb_q),
    .rdata_i    (rdata_b_i),
    .wb_we_i    (wb_we_i),
    .wb_waddr_i (wb_waddr_i),
    .wb_wdata_i (wb_wdata_i),
    .operand_o  (cap_b)
  );

  // Operands load only on capture; later writebacks (in OUT) are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (capture) begin
      op_a_q <= cap_a;
      op_b_q <= cap_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (in_issue) begin
      stall_cnt_q <= '0;
    end else if (in_wait) begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (force_cap) begin
      timeout_q <= 1'b1;
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_q  <= '0;
      stall_q <= '0;
    end else begin
      if (in_issue && rf_stall_i && (miss_q != '1)) begin
        miss_q <= miss_q + CntWidth'(1);
      end
      if (in_wait && (stall_q != '1)) begin
        stall_q <= stall_q + CntWidth'(1);
      end
    end
  end

  assign raddr_a_o       = (in_issue || in_wait) ? ra_q : RegZero;
  assign raddr_b_o       = (in_issue || in_wait) ? rb_q : RegZero;
  assign op_valid_o      = in_out;
  assign op_a_o          = op_a_q;
  assign op_b_o          = op_b_q;
  assign stall_timeout_o = timeout_q;
  assign miss_count_o    = miss_q;
  assign stall_cycles_o  = stall_q;

endmodule
